// File: rtl/layer_serializer_if.sv
// ============================================================================
//  Module      : layer_serializer_if
//  Description : Parallel-capture / serial-emit bundle for layer_serializer.
//                Argmax signals exist only when SER_ARGMAX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface layer_serializer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    o_valid;
    logic [dataWidth-1:0]    o_data;
    logic                    o_last;
    logic                    busy;
    logic                    overrun;
`ifdef SER_ARGMAX_EN
    logic [IW-1:0]           o_max_idx;
    logic                    o_max_valid;

    modport master (
        input  i_valid, i_data,
        output o_valid, o_data, o_last, busy, overrun, o_max_idx, o_max_valid
    );
    modport slave (
        output i_valid, i_data,
        input  o_valid, o_data, o_last, busy, overrun, o_max_idx, o_max_valid
    );
`else
    modport master (
        input  i_valid, i_data,
        output o_valid, o_data, o_last, busy, overrun
    );
    modport slave (
        output i_valid, i_data,
        input  o_valid, o_data, o_last, busy, overrun
    );
`endif
endinterface

`default_nettype wire

// File: rtl/layer_serializer.sv
// ============================================================================
//  Module      : layer_serializer
//  Description : Captures NN neuron results in one cycle and streams them one
//                word per cycle, neuron 0 first. Optional running argmax is
//                enabled by defining SER_ARGMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    layer_serializer_if.master  bus
);
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] c_last = CW'(NN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [dataWidth-1:0] r_cap [NN];
    logic                 r_valid;
    logic [dataWidth-1:0] r_data;
    logic                 r_last;
    logic                 r_overrun;

    logic [dataWidth-1:0] w_in [NN];
    logic                 w_trig;
    logic                 w_at_last;
    logic                 w_load;
    logic [CW-1:0]        w_cnt_nxt;
    logic [dataWidth-1:0] w_next_word;
    logic                 w_unused_bits;

    for (genvar k = 0; k < NN; k++) begin : g_unpack
        assign w_in[k] = bus.i_data[k*dataWidth +: dataWidth];
    end

    // Only bit 0 of the per-neuron valid vector triggers a capture.
    assign w_trig        = bus.i_valid[0];
    assign w_unused_bits = ^bus.i_valid;
    assign w_at_last     = (r_cnt == c_last);
    assign w_load        = w_trig && ((r_state == ST_IDLE) || w_at_last);
    assign w_cnt_nxt     = r_cnt + 1'b1;
    assign w_next_word   = r_cap[w_cnt_nxt];

    // Output registers always hold the word currently on the bus; r_cnt is its index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < NN; k++) r_cap[k] <= '0;
        end else begin
            if (w_load) begin
                r_cap   <= w_in;
                r_cnt   <= '0;
                r_valid <= 1'b1;
                r_data  <= w_in[0];
                r_last  <= (NN == 1);
                r_state <= ST_SHIFT;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_SHIFT: begin
                        if (!w_at_last) begin
                            r_cnt  <= w_cnt_nxt;
                            r_data <= w_next_word;
                            r_last <= (w_cnt_nxt == c_last);
                            if (w_trig) r_overrun <= 1'b1;
                        end else begin
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_last  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_last  = r_last;
    assign bus.busy    = (r_state == ST_SHIFT);
    assign bus.overrun = r_overrun;

`ifdef SER_ARGMAX_EN
    logic signed [dataWidth-1:0] r_max;
    logic [CW-1:0]               r_run_idx;
    logic [CW-1:0]               r_max_idx;
    logic                        r_max_valid;

    // Strict greater-than keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max       <= '0;
            r_run_idx   <= '0;
            r_max_idx   <= '0;
            r_max_valid <= 1'b0;
        end else begin
            r_max_valid <= 1'b0;
            if (w_load) begin
                r_max     <= $signed(w_in[0]);
                r_run_idx <= '0;
            end else if ((r_state == ST_SHIFT) && !w_at_last &&
                         ($signed(w_next_word) > r_max)) begin
                r_max     <= $signed(w_next_word);
                r_run_idx <= w_cnt_nxt;
            end
            if ((r_state == ST_SHIFT) && w_at_last) begin
                r_max_idx   <= r_run_idx;
                r_max_valid <= 1'b1;
            end
        end
    end

    assign bus.o_max_idx   = r_max_idx;
    assign bus.o_max_valid = r_max_valid;
`endif

endmodule

`default_nettype wire

// File: doc/layer_serializer.md
# layer_serializer

Sits between two fully-connected layers. Captures the NN parallel neuron results of one layer in a single cycle, then streams them one word per cycle into the next layer's shared `x_in`/`x_valid` input, neuron 0 first. A layer block with NN neurons feeds this block, and this block feeds the next layer block. In the output layer, an optional running argmax reports the winning neuron index.

## Interface
Parameters:
- `NN`, 30: number of neuron results per vector.
- `dataWidth`, 16: width of one result word, two's complement.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, NN: per-neuron valid from the upstream layer. Only bit 0 triggers a capture; the other bits are ignored.
- `i_data`, in, NN*dataWidth: neuron k's result sits at `[k*dataWidth +: dataWidth]`.
- `o_valid`, out, 1: a word is present on `o_data`; drives the next layer's `x_valid`.
- `o_data`, out, dataWidth: the current word; drives the next layer's `x_in`.
- `o_last`, out, 1: high together with `o_valid` on word NN-1.
- `busy`, out, 1: high while a vector is being emitted.
- `overrun`, out, 1: sticky; set when a capture arrives while a vector is still being emitted.
- `o_max_idx`, out, $clog2(NN): argmax result. Present only with `SER_ARGMAX_EN`.
- `o_max_valid`, out, 1: one-cycle strobe for the argmax result. Present only with `SER_ARGMAX_EN`.

## Operation
- Internal state: a capture register of NN words, a word counter `cnt` (0..NN-1) and the FSM states IDLE and SHIFT.
- **IDLE:**
  - If `i_valid[0]`=1: load all of `i_data` into the capture register, set `cnt`=0 and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each cycle drives `o_valid`=1 and `o_data`=word[`cnt`].
  - If `cnt`<NN-1: increment `cnt`.
  - If `cnt`=NN-1: assert `o_last`, then:
    - with `i_valid[0]`=1 in that same cycle: reload the capture register, set `cnt`=0 and stay in SHIFT (back-to-back vectors, no bubble, no overrun);
    - otherwise return to IDLE.
- **Overrun:** `i_valid[0]`=1 while in SHIFT with `cnt`<NN-1.
  - The new vector is dropped.
  - The capture register is not disturbed and emission continues unchanged.
  - `overrun` is set and stays set until reset.
- `busy` = (state == SHIFT).
- Words pass through unmodified; no arithmetic is applied to the data path.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `overrun`=0, `o_max_idx`=0, `o_max_valid`=0; FSM in IDLE, `cnt`=0.
- All outputs are registered.
- Latency: `i_valid[0]` sampled at edge E gives word 0 valid in the cycle after E. Words 0..NN-1 follow on NN consecutive cycles.
- The minimum capture-to-capture spacing without overrun is NN cycles.
- `rst` asserted mid-vector clears everything immediately, including the capture register contents. Remaining words are not emitted.
- After `rst` deasserts, the first `i_valid[0]` is handled as a fresh capture.

## Configuration
- `SER_ARGMAX_EN` defined:
  - A running signed maximum and its index are updated as each word is emitted.
  - On ties, the lower index is kept.
  - The maximum is reinitialised from word 0 at the start of every vector.
  - `o_max_idx` is registered one cycle after `o_last`. `o_max_valid` pulses for exactly one cycle at that same time.
  - `o_max_idx` holds its value until the next result.
- `SER_ARGMAX_EN` undefined: the `o_max_idx`/`o_max_valid` ports and all comparator logic are absent.

## Test plan
- **Single vector:** NN=30, word k = k+1, one-cycle `i_valid`=all ones → `o_valid` high for exactly 30 cycles carrying 1..30 in order; `o_last` only on the 30; `busy` falls the cycle after; `overrun`=0.
- **Back-to-back:** second vector (values 100+k) presented in the `o_last` cycle of the first → 60 contiguous valid cycles, no gap, second stream 100..129, `overrun`=0.
- **Overrun:** second capture at word 10 of the first vector → first stream completes unchanged (1..30); `overrun`=1 and stays set; second vector is never emitted.
- **Reset mid-stream:** drive `rst`=0 at word 5 → all outputs 0 within the same cycle (asynchronous); after release, a new vector streams correctly from word 0.
- **Argmax (`SER_ARGMAX_EN`):**
  - Vector with word 17 = 0x7FFF and word 3 = 0x7FFF → `o_max_idx`=3 with a one-cycle `o_max_valid`, one cycle after `o_last`.
  - Vector of all 0x8000 → `o_max_idx`=0.
- **Trigger bits:** `i_valid` = 30'h3FFFFFFE (bit 0 low) → no capture, `o_valid` stays 0.
